// File: rtl/vliw_pkg.sv
// Shared VLIW types: slot count, register/data widths and the per-slot decoded bundle.
// Pure type/parameter package, no state.
package vliw_pkg;

   localparam int NSLOT  = 4;
   localparam int NREG   = 128;
   localparam int XLEN   = 32;
   localparam int RIDX_W = 7;

   typedef logic [RIDX_W-1:0] reg_idx_t;
   typedef logic [XLEN-1:0]   word_t;

   typedef struct packed {
      reg_idx_t [1:0] rs;
      reg_idx_t       rd;
      logic           mre;
   } bundle_t;

   // Slot k of the flat decode buses; sources [2k] and [2k+1] belong to slot k.
   function automatic bundle_t slot_bundle(
      input logic [NSLOT*2*RIDX_W-1:0] rs,
      input logic [NSLOT*RIDX_W-1:0]   rd,
      input logic [NSLOT-1:0]          mre,
      input int                        k
   );
      bundle_t b;
      b.rs[0] = rs[(2*k)*RIDX_W +: RIDX_W];
      b.rs[1] = rs[(2*k+1)*RIDX_W +: RIDX_W];
      b.rd    = rd[k*RIDX_W +: RIDX_W];
      b.mre   = mre[k];
      return b;
   endfunction

endpackage

// File: rtl/regfile_bank.sv
// Register bank: NSLOT write ports, 2*NSLOT asynchronous read ports, x0 reads as zero.
// Latency: writes land at the clock edge, reads are combinational; no backpressure.
// Same-index writes in one cycle resolve to the highest-numbered slot.
module regfile_bank
   import vliw_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NSLOT-1:0]              we,
   input  logic [NSLOT*RIDX_W-1:0]       wa,
   input  logic [NSLOT*XLEN-1:0]         wd,
   input  logic [2*NSLOT*RIDX_W-1:0]     ra,
   output logic [2*NSLOT*XLEN-1:0]       rdata
);

   word_t mem [NREG];

   // Ascending slot loop: the last non-blocking write to an index wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else begin
         for (int k = 0; k < NSLOT; k++) begin
            if (we[k] && (wa[k*RIDX_W +: RIDX_W] != '0))
               mem[wa[k*RIDX_W +: RIDX_W]] <= wd[k*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int j = 0; j < 2*NSLOT; j++) begin
         if (ra[j*RIDX_W +: RIDX_W] != '0)
            rdata[j*XLEN +: XLEN] = mem[ra[j*RIDX_W +: RIDX_W]];
      end
   end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: register file read, load scoreboard and hazard stall (WB_BYPASS_EN adds wb->read bypass).
// Latency 1: operands registered the cycle after accept.
// stall holds the outputs; of_stall combinationally refuses a bundle waiting on a load.
module operand_fetch
   import vliw_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          stall,
   input  logic                          dec_valid,
   input  logic [NSLOT*2*RIDX_W-1:0]     dec_rs,
   input  logic [NSLOT*RIDX_W-1:0]       dec_rd,
   input  logic [NSLOT-1:0]              dec_mre,
   input  logic [NSLOT-1:0]              wb_we,
   input  logic [NSLOT*RIDX_W-1:0]       wb_rd,
   input  logic [NSLOT*XLEN-1:0]         wb_data,
   input  logic [NSLOT-1:0]              wb_mre,
   output logic                          of_stall,
   output logic                          of_valid,
   output logic [NSLOT*RIDX_W-1:0]       of_rd,
   output logic [NSLOT*2*XLEN-1:0]       of_data
);

   bundle_t                     bnd [NSLOT];
   logic [NREG-1:0]             busy;
   logic [NREG-1:0]             busy_eff;
   logic [NREG-1:0]             busy_clr;
   logic [NREG-1:0]             busy_set;
   logic [2*NSLOT*XLEN-1:0]     rf_rdata;
   logic [2*NSLOT*XLEN-1:0]     opnd;
   logic                        hazard;
   logic                        accept;

   regfile_bank u_rf (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wb_we),
      .wa    (wb_rd),
      .wd    (wb_data),
      .ra    (dec_rs),
      .rdata (rf_rdata)
   );

   always_comb begin
      for (int k = 0; k < NSLOT; k++) bnd[k] = slot_bundle(dec_rs, dec_rd, dec_mre, k);
   end

   always_comb begin
      busy_clr = '0;
      for (int k = 0; k < NSLOT; k++) begin
         if (wb_we[k] && wb_mre[k]) busy_clr[wb_rd[k*RIDX_W +: RIDX_W]] = 1'b1;
      end
      busy_clr[0] = 1'b0;
   end

   always_comb begin
      busy_set = '0;
      if (accept) begin
         for (int k = 0; k < NSLOT; k++) begin
            if (bnd[k].mre) busy_set[bnd[k].rd] = 1'b1;
         end
      end
      busy_set[0] = 1'b0;
   end

`ifdef WB_BYPASS_EN
   // Load data returning this cycle is forwarded, so its clear is visible immediately.
   assign busy_eff = busy & ~busy_clr;

   always_comb begin
      opnd = rf_rdata;
      for (int j = 0; j < 2*NSLOT; j++) begin
         for (int k = 0; k < NSLOT; k++) begin
            if (wb_we[k] && (wb_rd[k*RIDX_W +: RIDX_W] != '0) &&
                (wb_rd[k*RIDX_W +: RIDX_W] == dec_rs[j*RIDX_W +: RIDX_W]))
               opnd[j*XLEN +: XLEN] = wb_data[k*XLEN +: XLEN];
         end
      end
   end
`else
   // Without forwarding the busy bit drops at the write edge, exactly when the stored value becomes readable.
   assign busy_eff = busy;
   assign opnd     = rf_rdata;
`endif

   always_comb begin
      hazard = 1'b0;
      for (int k = 0; k < NSLOT; k++) begin
         if (busy_eff[bnd[k].rs[0]] || busy_eff[bnd[k].rs[1]]) hazard = 1'b1;
         if (bnd[k].mre && busy_eff[bnd[k].rd])                 hazard = 1'b1;
      end
   end

   assign of_stall = dec_valid & hazard;
   assign accept   = dec_valid & ~stall & ~of_stall;

   // Set after clear: a load re-issued to a register being returned stays busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= (busy & ~busy_clr) | busy_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         of_valid <= 1'b0;
         of_rd    <= '0;
         of_data  <= '0;
      end else if (!stall) begin
         of_valid <= accept;
         if (accept) begin
            of_rd   <= dec_rd;
            of_data <= opnd;
         end
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: stimulus pushes expected bundles, a monitor pops on each consumed output.
module tb_operand_fetch;

   logic         clk;
   logic         rst_n;
   logic         stall;
   logic         dec_valid;
   logic [55:0]  dec_rs;
   logic [27:0]  dec_rd;
   logic [3:0]   dec_mre;
   logic [3:0]   wb_we;
   logic [27:0]  wb_rd;
   logic [127:0] wb_data;
   logic [3:0]   wb_mre;
   logic         of_stall;
   logic         of_valid;
   logic [27:0]  of_rd;
   logic [255:0] of_data;

   int checks = 0;
   int errors = 0;
   logic [283:0] sb [$];

   operand_fetch dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall     (stall),
      .dec_valid (dec_valid),
      .dec_rs    (dec_rs),
      .dec_rd    (dec_rd),
      .dec_mre   (dec_mre),
      .wb_we     (wb_we),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .wb_mre    (wb_mre),
      .of_stall  (of_stall),
      .of_valid  (of_valid),
      .of_rd     (of_rd),
      .of_data   (of_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [55:0] rs8(input logic [6:0] a0, a1, a2, a3, a4, a5, a6, a7);
      return {a7, a6, a5, a4, a3, a2, a1, a0};
   endfunction

   function automatic logic [27:0] rd4(input logic [6:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   function automatic logic [127:0] wd4(input logic [31:0] d0, d1, d2, d3);
      return {d3, d2, d1, d0};
   endfunction

   function automatic logic [255:0] d8(input logic [31:0] d0, d1, d2, d3, d4, d5, d6, d7);
      return {d7, d6, d5, d4, d3, d2, d1, d0};
   endfunction

   task automatic chk(input string name, input logic [283:0] got, input logic [283:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // One cycle of stimulus; a bundle expected to be accepted is queued for the monitor.
   task automatic step(input string name, input logic dv, input logic [55:0] rs, input logic [27:0] rd,
                       input logic [3:0] mre, input logic [3:0] we, input logic [27:0] wrd,
                       input logic [127:0] wd, input logic [3:0] wm, input logic exp_stall,
                       input logic [255:0] exp_data);
      dec_valid = dv;  dec_rs = rs;  dec_rd = rd;  dec_mre = mre;
      wb_we = we;  wb_rd = wrd;  wb_data = wd;  wb_mre = wm;  stall = 1'b0;
      @(negedge clk);
      if (dv) begin
         chk({name, "_stall"}, {283'd0, of_stall}, {283'd0, exp_stall});
         if (!exp_stall) sb.push_back({rd, exp_data});
      end
      @(posedge clk); #1;
   endtask

   task automatic issue(input string name, input logic [55:0] rs, input logic [27:0] rd,
                        input logic [3:0] mre, input logic exp_stall, input logic [255:0] exp_data);
      step(name, 1'b1, rs, rd, mre, 4'b0, '0, '0, 4'b0, exp_stall, exp_data);
   endtask

   task automatic wr(input logic [3:0] we, input logic [27:0] wrd, input logic [127:0] wd, input logic [3:0] wm);
      step("wr", 1'b0, '0, '0, 4'b0, we, wrd, wd, wm, 1'b0, '0);
   endtask

   always @(negedge clk) begin
      logic [283:0] exp;
      if (rst_n && of_valid && !stall) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: of_rd %h of_data %h with nothing expected", of_rd, of_data);
         end else begin
            exp = sb.pop_front();
            if ({of_rd, of_data} !== exp) begin
               errors++;
               $display("FAIL operands: got rd %h data %h expected rd %h data %h",
                        of_rd, of_data, exp[283:256], exp[255:0]);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;  stall = 1'b0;  dec_valid = 1'b0;  dec_rs = '0;  dec_rd = '0;  dec_mre = '0;
      wb_we = '0;  wb_rd = '0;  wb_data = '0;  wb_mre = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_valid", {283'd0, of_valid}, '0);
      chk("reset_data", {28'd0, of_data}, '0);
      chk("reset_rd", {256'd0, of_rd}, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("valid_before_accept", {283'd0, of_valid}, '0);
      @(posedge clk); #1;

      // Registers read zero after reset
      issue("t1", rs8(1, 2, 3, 4, 5, 6, 7, 8), rd4(0, 0, 0, 0), 4'b0000, 1'b0, '0);

      // Same-index writes: slot 3 wins; write to x0 dropped
      wr(4'b1011, rd4(5, 0, 0, 5), wd4(32'hDEADBEEF, 32'hFFFFFFFF, 32'h0, 32'h12345678), 4'b0000);
      issue("t2", rs8(5, 0, 0, 0, 0, 0, 0, 5), rd4(0, 0, 0, 0), 4'b0000, 1'b0,
            d8(32'h12345678, 0, 0, 0, 0, 0, 0, 32'h12345678));

      // Loads to x0 never create a hazard
      issue("t3_ld_x0", rs8(0, 0, 0, 0, 0, 0, 0, 0), rd4(0, 0, 0, 0), 4'b0001, 1'b0, '0);
      issue("t3_rd_x0", rs8(0, 0, 0, 0, 0, 0, 0, 0), rd4(0, 0, 0, 0), 4'b1111, 1'b0, '0);

      // Load to r10, then WAW and RAW hazards until the load returns
      issue("t4_ld", rs8(0, 0, 0, 0, 0, 0, 0, 0), rd4(0, 10, 0, 0), 4'b0010, 1'b0, '0);
      issue("t4_waw", rs8(0, 0, 0, 0, 0, 0, 0, 0), rd4(10, 0, 0, 0), 4'b0001, 1'b1, '0);
      issue("t4_raw", rs8(10, 0, 0, 0, 0, 0, 0, 0), rd4(0, 0, 0, 0), 4'b0000, 1'b1, '0);
`ifdef WB_BYPASS_EN
      step("t4_clr", 1'b1, rs8(10, 0, 0, 0, 0, 0, 0, 0), rd4(0, 0, 0, 0), 4'b0000,
           4'b0100, rd4(0, 0, 10, 0), wd4(0, 0, 32'hA5A50010, 0), 4'b0100,
           1'b0, d8(32'hA5A50010, 0, 0, 0, 0, 0, 0, 0));
`else
      step("t4_clr", 1'b1, rs8(10, 0, 0, 0, 0, 0, 0, 0), rd4(0, 0, 0, 0), 4'b0000,
           4'b0100, rd4(0, 0, 10, 0), wd4(0, 0, 32'hA5A50010, 0), 4'b0100,
           1'b1, '0);
      issue("t4_late", rs8(10, 0, 0, 0, 0, 0, 0, 0), rd4(0, 0, 0, 0), 4'b0000, 1'b0,
            d8(32'hA5A50010, 0, 0, 0, 0, 0, 0, 0));
`endif

      // Downstream stall holds outputs while writes continue
      wr(4'b0001, rd4(7, 0, 0, 0), wd4(32'h77770001, 0, 0, 0), 4'b0000);
      issue("t5", rs8(0, 0, 0, 0, 0, 0, 0, 7), rd4(11, 12, 13, 14), 4'b0000, 1'b0,
            d8(0, 0, 0, 0, 0, 0, 0, 32'h77770001));
      for (int i = 0; i < 3; i++) begin
         dec_valid = 1'b0;  stall = 1'b1;
         wb_we = (i == 0) ? 4'b0001 : 4'b0000;
         wb_rd = rd4(7, 0, 0, 0);  wb_data = wd4(32'h77770002, 0, 0, 0);  wb_mre = 4'b0000;
         @(negedge clk);
         chk("t5_hold_valid", {283'd0, of_valid}, {283'd0, 1'b1});
         chk("t5_hold_data", {28'd0, of_data}, {28'd0, d8(0, 0, 0, 0, 0, 0, 0, 32'h77770001)});
         chk("t5_hold_rd", {256'd0, of_rd}, {256'd0, rd4(11, 12, 13, 14)});
         @(posedge clk); #1;
      end
      issue("t5_after", rs8(7, 0, 0, 0, 0, 0, 0, 0), rd4(0, 0, 0, 0), 4'b0000, 1'b0,
            d8(32'h77770002, 0, 0, 0, 0, 0, 0, 0));

      // Reset while r10 is busy forgets the load
      issue("t6_ld", rs8(0, 0, 0, 0, 0, 0, 0, 0), rd4(10, 0, 0, 0), 4'b0001, 1'b0, '0);
      dec_valid = 1'b1;  dec_rs = rs8(10, 0, 0, 0, 0, 0, 0, 0);  dec_rd = '0;  dec_mre = '0;
      wb_we = '0;  wb_mre = '0;
      @(negedge clk);
      chk("t6_busy_stall", {283'd0, of_stall}, {283'd0, 1'b1});
      #1 rst_n = 1'b0;
      #1;
      chk("t6_async_stall", {283'd0, of_stall}, '0);
      chk("t6_async_valid", {283'd0, of_valid}, '0);
      chk("t6_async_data", {28'd0, of_data}, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      issue("t6_after", rs8(10, 5, 7, 0, 0, 0, 0, 0), rd4(0, 0, 0, 0), 4'b0000, 1'b0, '0);

      // Drain, bounded
      step("idle", 1'b0, '0, '0, 4'b0, 4'b0, '0, '0, 4'b0, 1'b0, '0);
      for (int i = 0; i < 10 && sb.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      chk("drain_empty", 284'(sb.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
